// File: rtl/avm_accel_pkg.sv
// Shared definitions for the vector MAC bus master: FSM states, MODE codes
// and the accumulator width rule.
package avm_accel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_B  = 3'd2,
        ST_ACC   = 3'd3,
        ST_WR_HI = 3'd4,
        ST_WR_LO = 3'd5,
        ST_NEXT  = 3'd6,
        ST_FIN   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        MODE_SUM  = 2'd0,
        MODE_MAC  = 2'd1,
        MODE_SSD  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    function automatic int acc_width(input int data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/mac_term_unit.sv
// Combinational mode arithmetic: forms the per-element term from two unsigned
// operands and adds it to the running accumulator, wrapping at ACC_WIDTH bits.
module mac_term_unit
    import avm_accel_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH)
) (
    input  mode_t                 mode,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [ACC_WIDTH-1:0]  acc,
    output logic [ACC_WIDTH-1:0]  acc_next
);

    logic [ACC_WIDTH-1:0] a_ext;
    logic [ACC_WIDTH-1:0] b_ext;
    logic [ACC_WIDTH-1:0] diff;
    logic [ACC_WIDTH-1:0] term;

    always_comb begin
        a_ext = ACC_WIDTH'(a);
        b_ext = ACC_WIDTH'(b);
        // |a-b| keeps the squared-difference term exact for unsigned operands
        diff  = (a >= b) ? (a_ext - b_ext) : (b_ext - a_ext);
        case (mode)
            MODE_SUM: term = a_ext + b_ext;
            MODE_MAC: term = a_ext * b_ext;
            MODE_SSD: term = diff * diff;
            default:  term = '0;
        endcase
        acc_next = acc + term;
    end

endmodule

// File: rtl/avm_vector_mac_master.sv
// Avalon-MM master that streams COUNT pairs of SIZE-element vectors, reduces
// each pair with the selected mode and writes the 2-word result per pair.
module avm_vector_mac_master
    import avm_accel_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int SIZE_WIDTH  = 19,
    parameter int COUNT_WIDTH = 11
) (
    input  logic                   CSI_CLOCK_CLK,
    input  logic                   CSI_CLOCK_RESET,
    input  logic                   GO,
    input  logic [1:0]             MODE,
    input  logic [SIZE_WIDTH-1:0]  SIZE,
    input  logic [COUNT_WIDTH-1:0] COUNT,
    input  logic [ADDR_WIDTH-1:0]  SRC_A_BASE,
    input  logic [ADDR_WIDTH-1:0]  SRC_B_BASE,
    input  logic [ADDR_WIDTH-1:0]  DST_BASE,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR,
    output logic [ADDR_WIDTH-1:0]  AVM_AVALONMASTER_ADDRESS,
    output logic                   AVM_AVALONMASTER_READ,
    output logic                   AVM_AVALONMASTER_WRITE,
    output logic [DATA_WIDTH-1:0]  AVM_AVALONMASTER_WRITEDATA,
    input  logic [DATA_WIDTH-1:0]  AVM_AVALONMASTER_READDATA,
    input  logic                   AVM_AVALONMASTER_WAITREQUEST
);

    localparam int ACC_WIDTH  = acc_width(DATA_WIDTH);
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);

    state_t                 state;
    mode_t                  mode_q;
    logic [SIZE_WIDTH-1:0]  size_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [ADDR_WIDTH-1:0]  src_a_q;
    logic [ADDR_WIDTH-1:0]  src_b_q;
    logic [ADDR_WIDTH-1:0]  dst_q;
    logic [COUNT_WIDTH-1:0] vec_idx;
    logic [SIZE_WIDTH-1:0]  elem_idx;
    // Vectors are contiguous, so vec_idx*SIZE+elem_idx is a plain running count
    logic [ADDR_WIDTH-1:0]  lin_idx;
    logic [DATA_WIDTH-1:0]  a_q;
    logic [DATA_WIDTH-1:0]  b_q;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   acc_next;

    logic [SIZE_WIDTH:0]    elem_inc;
    logic [COUNT_WIDTH:0]   vec_inc;
    logic [ADDR_WIDTH-1:0]  lin_inc;
    logic                   elem_last;
    logic                   vec_last;
    logic                   stall;

    assign elem_inc  = {1'b0, elem_idx} + {{SIZE_WIDTH{1'b0}}, 1'b1};
    assign vec_inc   = {1'b0, vec_idx} + {{COUNT_WIDTH{1'b0}}, 1'b1};
    assign lin_inc   = lin_idx + ADDR_WIDTH'(1);
    assign elem_last = elem_inc >= {1'b0, size_q};
    assign vec_last  = vec_inc >= {1'b0, count_q};
    assign stall     = AVM_AVALONMASTER_WAITREQUEST;

    function automatic logic [ADDR_WIDTH-1:0] elem_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [ADDR_WIDTH-1:0] idx);
        return base + (idx << BYTE_SHIFT);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] dst_addr(input logic [ADDR_WIDTH-1:0] base,
                                                       input logic [ADDR_WIDTH-1:0] vec);
        return base + (vec << (BYTE_SHIFT + 1));
    endfunction

    mac_term_unit #(.DATA_WIDTH(DATA_WIDTH)) u_term (
        .mode     (mode_q),
        .a        (a_q),
        .b        (b_q),
        .acc      (acc),
        .acc_next (acc_next)
    );

    always_ff @(posedge CSI_CLOCK_CLK) begin
        if (!CSI_CLOCK_RESET) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_SUM;
            size_q   <= '0;
            count_q  <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            vec_idx  <= '0;
            elem_idx <= '0;
            lin_idx  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            AVM_AVALONMASTER_ADDRESS   <= '0;
            AVM_AVALONMASTER_READ      <= 1'b0;
            AVM_AVALONMASTER_WRITE     <= 1'b0;
            AVM_AVALONMASTER_WRITEDATA <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (GO) begin
                        mode_q   <= mode_t'(MODE);
                        size_q   <= SIZE;
                        count_q  <= COUNT;
                        src_a_q  <= SRC_A_BASE;
                        src_b_q  <= SRC_B_BASE;
                        dst_q    <= DST_BASE;
                        vec_idx  <= '0;
                        elem_idx <= '0;
                        lin_idx  <= '0;
                        acc      <= '0;
                        BUSY     <= 1'b1;
                        ERR      <= (mode_t'(MODE) == MODE_RSVD);
                        // Empty or reserved jobs pass through NEXT so DONE lands two cycles after GO
                        if (mode_t'(MODE) == MODE_RSVD || COUNT == '0) begin
                            state <= ST_NEXT;
                        end else if (SIZE == '0) begin
                            state <= ST_WR_HI;
                            AVM_AVALONMASTER_WRITE     <= 1'b1;
                            AVM_AVALONMASTER_ADDRESS   <= DST_BASE;
                            AVM_AVALONMASTER_WRITEDATA <= '0;
                        end else begin
                            state <= ST_RD_A;
                            AVM_AVALONMASTER_READ    <= 1'b1;
                            AVM_AVALONMASTER_ADDRESS <= SRC_A_BASE;
                        end
                    end
                end
                ST_RD_A: begin
                    if (!stall) begin
                        a_q   <= AVM_AVALONMASTER_READDATA;
                        AVM_AVALONMASTER_ADDRESS <= elem_addr(src_b_q, lin_idx);
                        state <= ST_RD_B;
                    end
                end
                ST_RD_B: begin
                    if (!stall) begin
                        b_q   <= AVM_AVALONMASTER_READDATA;
                        AVM_AVALONMASTER_READ <= 1'b0;
                        state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc     <= acc_next;
                    lin_idx <= lin_inc;
                    if (!elem_last) begin
                        elem_idx <= elem_inc[SIZE_WIDTH-1:0];
                        state    <= ST_RD_A;
                        AVM_AVALONMASTER_READ    <= 1'b1;
                        AVM_AVALONMASTER_ADDRESS <= elem_addr(src_a_q, lin_inc);
                    end else begin
                        state <= ST_WR_HI;
                        AVM_AVALONMASTER_WRITE     <= 1'b1;
                        AVM_AVALONMASTER_ADDRESS   <= dst_addr(dst_q, ADDR_WIDTH'(vec_idx));
                        AVM_AVALONMASTER_WRITEDATA <= acc_next[ACC_WIDTH-1:DATA_WIDTH];
                    end
                end
                ST_WR_HI: begin
                    if (!stall) begin
                        AVM_AVALONMASTER_ADDRESS   <= AVM_AVALONMASTER_ADDRESS + ADDR_WIDTH'(BYTES);
                        AVM_AVALONMASTER_WRITEDATA <= acc[DATA_WIDTH-1:0];
                        state <= ST_WR_LO;
                    end
                end
                ST_WR_LO: begin
                    if (!stall) begin
                        AVM_AVALONMASTER_WRITE <= 1'b0;
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    acc      <= '0;
                    elem_idx <= '0;
                    vec_idx  <= vec_inc[COUNT_WIDTH-1:0];
                    if (mode_q == MODE_RSVD || vec_last) begin
                        state <= ST_FIN;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                    end else if (size_q == '0) begin
                        state <= ST_WR_HI;
                        AVM_AVALONMASTER_WRITE     <= 1'b1;
                        AVM_AVALONMASTER_ADDRESS   <= dst_addr(dst_q, ADDR_WIDTH'(vec_inc));
                        AVM_AVALONMASTER_WRITEDATA <= '0;
                    end else begin
                        state <= ST_RD_A;
                        AVM_AVALONMASTER_READ    <= 1'b1;
                        AVM_AVALONMASTER_ADDRESS <= elem_addr(src_a_q, lin_idx);
                    end
                end
                ST_FIN: begin
                    DONE  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avm_vector_mac_master.sv
// Bench for avm_vector_mac_master: memory-backed Avalon slave, job-level
// reference model with expected address/data queues, directed jobs.
module tb_avm_vector_mac_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [1:0]  mode_in = '0;
    logic [18:0] size_in = '0;
    logic [10:0] count_in = '0;
    logic [31:0] a_base = '0;
    logic [31:0] b_base = '0;
    logic [31:0] d_base = '0;
    logic        busy, done, err;
    logic [31:0] address;
    logic        read, write;
    logic [31:0] writedata;
    logic [31:0] readdata = '0;
    logic        waitreq = 1'b0;

    avm_vector_mac_master dut (
        .CSI_CLOCK_CLK                (clk),
        .CSI_CLOCK_RESET              (rst_n),
        .GO                           (go),
        .MODE                         (mode_in),
        .SIZE                         (size_in),
        .COUNT                        (count_in),
        .SRC_A_BASE                   (a_base),
        .SRC_B_BASE                   (b_base),
        .DST_BASE                     (d_base),
        .BUSY                         (busy),
        .DONE                         (done),
        .ERR                          (err),
        .AVM_AVALONMASTER_ADDRESS     (address),
        .AVM_AVALONMASTER_READ        (read),
        .AVM_AVALONMASTER_WRITE       (write),
        .AVM_AVALONMASTER_WRITEDATA   (writedata),
        .AVM_AVALONMASTER_READDATA    (readdata),
        .AVM_AVALONMASTER_WAITREQUEST (waitreq)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_wa_q[$];
    logic [31:0] exp_wd_q[$];
    logic [31:0] wr_log[$];

    bit  stall_en = 0;
    bit  force_stall = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  go_cyc = 0;
    int  xfer_cnt = 0;

    // ---------------- reference model ----------------
    task automatic model_job(input int m, input int sz, input int cnt,
                             input logic [31:0] ab, input logic [31:0] bb, input logic [31:0] db);
        longint unsigned acc, av, bv, t;
        logic [31:0] lin;
        if (m == 3) return;
        lin = 0;
        for (int v = 0; v < cnt; v++) begin
            acc = 0;
            for (int e = 0; e < sz; e++) begin
                exp_rd_q.push_back(ab + lin * 4);
                exp_rd_q.push_back(bb + lin * 4);
                av = longint'(mem[ab + lin * 4]);
                bv = longint'(mem[bb + lin * 4]);
                case (m)
                    0: t = av + bv;
                    1: t = av * bv;
                    default: t = (av > bv) ? (av - bv) * (av - bv) : (bv - av) * (bv - av);
                endcase
                acc += t;
                lin++;
            end
            exp_wa_q.push_back(db + 32'(v) * 8);
            exp_wd_q.push_back(acc[63:32]);
            exp_wa_q.push_back(db + 32'(v) * 8 + 4);
            exp_wd_q.push_back(acc[31:0]);
        end
    endtask

    // ---------------- slave + compare process ----------------
    bit          in_xfer = 0;
    bit          prev_accept = 0;
    bit          prev_stall = 0;
    int          stall_left = 0;
    logic [31:0] s_addr, s_wd;
    logic [1:0]  s_strb;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_xfer = 0; prev_accept = 0; prev_stall = 0; stall_left = 0;
            waitreq = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (read || write) check("rd_wr_exclusive", 64'(read && write), 0);
            if (!busy) check("idle_strobes", 64'({read, write}), 0);
            if (prev_stall) begin
                check("stall_addr_stable", address, s_addr);
                check("stall_strobe_stable", 64'({read, write}), 64'(s_strb));
                if (write) check("stall_wdata_stable", writedata, s_wd);
            end
            if (prev_accept) in_xfer = 0;
            prev_accept = 0;
            prev_stall = 0;
            if (read || write) begin
                if (!in_xfer) begin
                    in_xfer = 1;
                    stall_left = stall_en ? $urandom_range(0, 7) : 0;
                end
                if (force_stall || stall_left > 0) begin
                    waitreq = 1'b1;
                    if (stall_left > 0) stall_left--;
                    prev_stall = 1;
                    s_addr = address; s_wd = writedata; s_strb = {read, write};
                end else begin
                    waitreq = 1'b0;
                    prev_accept = 1;
                    xfer_cnt++;
                    if (read) begin
                        readdata = mem.exists(address) ? mem[address] : 32'hDEAD_BEEF;
                        if (exp_rd_q.size() == 0) check("unexpected_read", 64'(exp_rd_q.size()), 1);
                        else check("read_addr", address, exp_rd_q.pop_front());
                    end else begin
                        wr_log.push_back(writedata);
                        if (exp_wa_q.size() == 0) check("unexpected_write", 64'(exp_wa_q.size()), 1);
                        else begin
                            check("write_addr", address, exp_wa_q.pop_front());
                            check("write_data", writedata, exp_wd_q.pop_front());
                        end
                    end
                end
            end else begin
                waitreq = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_job(input logic [1:0] m, input int sz, input int cnt,
                             input logic [31:0] ab, input logic [31:0] bb, input logic [31:0] db);
        @(negedge clk);
        mode_in = m; size_in = 19'(sz); count_in = 11'(cnt);
        a_base = ab; b_base = bb; d_base = db;
        go = 1'b1;
        go_cyc = cyc;
        @(negedge clk);
        go = 1'b0;
        check("busy_after_go", 64'(busy), 1);
    endtask

    task automatic run_job(input logic [1:0] m, input int sz, input int cnt,
                           input logic [31:0] ab, input logic [31:0] bb, input logic [31:0] db,
                           input bit stall, input bit poke, input bit exp_err);
        int waited;
        exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete(); wr_log.delete();
        model_job(int'(m), sz, cnt, ab, bb, db);
        xfer_cnt = 0;
        done_cnt = 0;
        stall_en = stall;
        start_job(m, sz, cnt, ab, bb, db);
        waited = exp_rd_q.size() + exp_wa_q.size();
        xfer_cnt = 0;
        if (poke) begin
            repeat (3) @(negedge clk);
            mode_in = 2'd3; count_in = '0; go = 1'b1;
            @(negedge clk);
            go = 1'b0;
        end
        for (int i = 0; i < 4000 && done_cnt == 0; i++) @(negedge clk);
        check("done_within_budget", 64'(done_cnt != 0), 1);
        repeat (3) @(negedge clk);
        check("done_pulse_count", 64'(done_cnt), 1);
        check("busy_after_done", 64'(busy), 0);
        check("err_flag", 64'(err), 64'(exp_err));
        check("transfer_count", 64'(xfer_cnt), 64'(waited));
        check("reads_outstanding", 64'(exp_rd_q.size()), 0);
        check("writes_outstanding", 64'(exp_wa_q.size()), 0);
    endtask

    task automatic check_log(input string name, input int idx, input logic [31:0] exp);
        if (idx < wr_log.size()) check(name, wr_log[idx], exp);
        else check({name, "_missing"}, 64'(wr_log.size()), 64'(idx + 1));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        mem[32'h1000] = 1;  mem[32'h1004] = 2;  mem[32'h1008] = 3;
        mem[32'h2000] = 10; mem[32'h2004] = 20; mem[32'h2008] = 30;
        mem[32'h1100] = 32'hFFFF_FFFF; mem[32'h1104] = 2; mem[32'h1108] = 3; mem[32'h110C] = 4;
        mem[32'h2100] = 32'hFFFF_FFFF; mem[32'h2104] = 3; mem[32'h2108] = 5; mem[32'h210C] = 6;
        mem[32'h1200] = 5; mem[32'h2200] = 9;
        for (int i = 0; i < 12; i++) begin
            mem[32'h1300 + 32'(i) * 4] = $urandom;
            mem[32'h2300 + 32'(i) * 4] = $urandom;
            mem[32'h1400 + 32'(i) * 4] = $urandom;
            mem[32'h2400 + 32'(i) * 4] = $urandom;
        end

        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_err", 64'(err), 0);
        check("rst_strobes", 64'({read, write}), 0);
        check("rst_address", address, 0);
        check("rst_writedata", writedata, 0);
        rst_n = 1'b1;

        // sum mode, three elements
        run_job(2'd0, 3, 1, 32'h1000, 32'h2000, 32'h3000, 0, 0, 0);
        check_log("sum_hi", 0, 32'h0);
        check_log("sum_lo", 1, 32'h42);

        // MAC with full-width wrap into the high word, GO poked mid-job
        run_job(2'd1, 2, 2, 32'h1100, 32'h2100, 32'h3100, 0, 1, 0);
        check_log("mac_p0_hi", 0, 32'hFFFF_FFFE);
        check_log("mac_p0_lo", 1, 32'h0000_0007);
        check_log("mac_p1_hi", 2, 32'h0);
        check_log("mac_p1_lo", 3, 32'h27);

        // squared difference with random stalls
        run_job(2'd2, 1, 1, 32'h1200, 32'h2200, 32'h3200, 1, 0, 0);
        check_log("ssd_hi", 0, 32'h0);
        check_log("ssd_lo", 1, 32'd16);

        // random data, multiple vectors
        run_job(2'd2, 4, 3, 32'h1300, 32'h2300, 32'h3300, 1, 0, 0);
        run_job(2'd1, 3, 2, 32'h1400, 32'h2400, 32'h3400, 1, 0, 0);
        run_job(2'd0, 4, 3, 32'h1300, 32'h2400, 32'h3500, 0, 0, 0);

        // SIZE=0: zero results, no reads
        run_job(2'd1, 0, 2, 32'h1000, 32'h2000, 32'h3600, 0, 0, 0);
        check("size0_write_count", 64'(wr_log.size()), 4);
        for (int i = 0; i < 4; i++) check_log("size0_zero", i, 32'h0);

        // COUNT=0: no transfers, DONE two cycles after GO
        run_job(2'd0, 3, 0, 32'h1000, 32'h2000, 32'h3700, 0, 0, 0);
        check("count0_done_latency", 64'(done_cyc - go_cyc), 2);

        // reserved mode sets ERR; next valid job clears it
        run_job(2'd3, 3, 1, 32'h1000, 32'h2000, 32'h3800, 0, 0, 1);
        run_job(2'd0, 3, 1, 32'h1000, 32'h2000, 32'h3900, 0, 0, 0);
        check_log("after_err_lo", 1, 32'h42);

        // reset during a stalled WR_HI
        exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete(); wr_log.delete();
        model_job(0, 1, 1, 32'h1000, 32'h2000, 32'h3A00);
        stall_en = 0;
        done_cnt = 0;
        start_job(2'd0, 1, 1, 32'h1000, 32'h2000, 32'h3A00);
        for (int i = 0; i < 100 && exp_rd_q.size() != 0; i++) @(negedge clk);
        force_stall = 1;
        for (int i = 0; i < 100 && !write; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("abort_write_held", 64'(write), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_write", 64'(write), 0);
        check("abort_busy", 64'(busy), 0);
        check("abort_done", 64'(done), 0);
        check("abort_read", 64'(read), 0);
        check("abort_address", address, 0);
        rst_n = 1'b1;
        force_stall = 0;
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(done_cnt), 0);
        check("abort_stays_idle", 64'(busy), 0);
        run_job(2'd0, 3, 1, 32'h1000, 32'h2000, 32'h3B00, 1, 0, 0);
        check_log("post_abort_lo", 1, 32'h42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
